// File: rtl/nonogram_pkg.sv
// Shared nonogram solver constants and the queued option word type.
package nonogram_pkg;
    localparam int OPT_W           = 16;
    localparam int MAX_ROWS        = 11;
    localparam int MAX_COLS        = 11;
    localparam int MAX_NUM_OPTIONS = 84;
    localparam int QUEUE_DEPTH     = 2048;

    typedef logic [OPT_W-1:0] opt_word_t;
endpackage

// File: rtl/option_queue_if.sv
// Parser/solver side of the option queue: write strobes, pop, head word and status.
interface option_queue_if
    import nonogram_pkg::*;
#(
    parameter int WIDTH = OPT_W,
    parameter int CNT_W = $clog2(QUEUE_DEPTH + 1)
);
    logic             clear;
    logic             solving;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] max_count;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, solving, load_valid, load_data, pop, push, push_data,
        input  rd_data, rd_valid, count, max_count, full, overflow, underflow
    );

    modport slave (
        input  clear, solving, load_valid, load_data, pop, push, push_data,
        output rd_data, rd_valid, count, max_count, full, overflow, underflow
    );
endinterface

// File: rtl/option_queue_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port, no reset.
module option_queue_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/option_queue.sv
// Circular option FIFO: parser fills it while loading, solver pops and re-enqueues while solving.
module option_queue
    import nonogram_pkg::*;
#(
    parameter int WIDTH = OPT_W,
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    option_queue_if.slave q
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    LAST_PTR  = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, max_count_q, max_count_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;

    logic             wr_req, pop_req, wr_ok, pop_ok, ram_we;
    logic [WIDTH-1:0] wr_data, ram_rdata;

    always_comb begin
        wr_req  = q.solving ? q.push : q.load_valid;
        wr_data = q.solving ? q.push_data : q.load_data;
        pop_req = q.solving & q.pop;
        pop_ok  = pop_req && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full queue can still take the write.
        wr_ok   = wr_req && ((count_q < DEPTH_CNT) || pop_ok);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_req && !wr_ok);
        underflow_d = underflow_q | (pop_req && (count_q == '0));

        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        max_count_d = (count_d > max_count_q) ? count_d : max_count_q;

        if (q.clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            max_count_d = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        ram_we = wr_ok && !q.clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            max_count_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    option_queue_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign q.rd_valid  = (count_q != '0);
    assign q.full      = (count_q == DEPTH_CNT);
    assign q.rd_data   = q.rd_valid ? ram_rdata : '0;
    assign q.count     = count_q;
    assign q.max_count = max_count_q;
    assign q.overflow  = overflow_q;
    assign q.underflow = underflow_q;
endmodule

// File: tb/tb_option_queue.sv
// Directed bench for option_queue: a full-size instance and a DEPTH=4 instance for wrap/full cases.
module tb_option_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    option_queue_if #(.WIDTH(16), .CNT_W(12)) qb ();
    option_queue_if #(.WIDTH(16), .CNT_W(3))  qs ();

    option_queue #(.WIDTH(16), .DEPTH(2048), .CNT_W(12)) dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qb.slave)
    );

    option_queue #(.WIDTH(16), .DEPTH(4), .CNT_W(3)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qs.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        qb.clear = 0; qb.solving = 0; qb.load_valid = 0; qb.load_data = '0;
        qb.pop = 0; qb.push = 0; qb.push_data = '0;
        qs.clear = 0; qs.solving = 0; qs.load_valid = 0; qs.load_data = '0;
        qs.pop = 0; qs.push = 0; qs.push_data = '0;
    endtask

    task automatic test_reset();
        n_assert++; if (qb.count !== 12'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", qb.count); end
        n_assert++; if (qb.max_count !== 12'd0) begin n_fail++; $display("FAIL reset_max got %0d want 0", qb.max_count); end
        n_assert++; if (qb.rd_valid !== 1'b0 || qb.full !== 1'b0) begin n_fail++; $display("FAIL reset_valid_full got %b%b want 00", qb.rd_valid, qb.full); end
        n_assert++; if (qb.overflow !== 1'b0 || qb.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", qb.overflow, qb.underflow); end
        n_assert++; if (qb.rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got %h want 0000", qb.rd_data); end
        n_assert++; if (qs.count !== 3'd0 || qs.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_small got %0d/%b want 0/0", qs.count, qs.rd_valid); end
        $display("test_reset done");
    endtask

    task automatic test_load_pop();
        logic [15:0] words [5] = '{16'h0003, 16'h0005, 16'h0006, 16'h0001, 16'h0004};
        qb.solving = 0;
        for (int i = 0; i < 5; i++) begin
            qb.load_valid = 1; qb.load_data = words[i];
            step();
        end
        qb.load_valid = 0;
        n_assert++; if (qb.count !== 12'd5) begin n_fail++; $display("FAIL load_count got %0d want 5", qb.count); end
        n_assert++; if (qb.max_count !== 12'd5) begin n_fail++; $display("FAIL load_max got %0d want 5", qb.max_count); end
        qb.solving = 1;
        for (int i = 0; i < 5; i++) begin
            n_assert++; if (qb.rd_data !== words[i]) begin n_fail++; $display("FAIL pop_data[%0d] got %h want %h", i, qb.rd_data, words[i]); end
            qb.pop = 1;
            step();
            qb.pop = 0;
            n_assert++; if (qb.count !== 12'(4 - i)) begin n_fail++; $display("FAIL pop_count[%0d] got %0d want %0d", i, qb.count, 4 - i); end
            $display("pop %0d count=%0d", i, qb.count);
        end
        n_assert++; if (qb.rd_valid !== 1'b0 || qb.rd_data !== 16'h0000) begin n_fail++; $display("FAIL pop_empty got %b/%h want 0/0000", qb.rd_valid, qb.rd_data); end
        n_assert++; if (qb.underflow !== 1'b0) begin n_fail++; $display("FAIL pop_underflow got %b want 0", qb.underflow); end
    endtask

    task automatic test_empty_push_pop();
        qb.solving = 1; qb.push = 1; qb.push_data = 16'h0012; qb.pop = 1;
        step();
        qb.push = 0; qb.pop = 0;
        n_assert++; if (qb.underflow !== 1'b1) begin n_fail++; $display("FAIL epp_underflow got %b want 1", qb.underflow); end
        n_assert++; if (qb.count !== 12'd1) begin n_fail++; $display("FAIL epp_count got %0d want 1", qb.count); end
        n_assert++; if (qb.rd_data !== 16'h0012) begin n_fail++; $display("FAIL epp_data got %h want 0012", qb.rd_data); end
        qb.clear = 1; step(); qb.clear = 0;
        n_assert++; if (qb.underflow !== 1'b0 || qb.count !== 12'd0) begin n_fail++; $display("FAIL epp_clear got %b/%0d want 0/0", qb.underflow, qb.count); end
        $display("test_empty_push_pop done");
    endtask

    task automatic test_ignore();
        qb.solving = 0; qb.load_valid = 1; qb.load_data = 16'h1111;
        step();
        qb.load_valid = 0; qb.pop = 1; qb.push = 1; qb.push_data = 16'h7777;
        step();
        qb.pop = 0; qb.push = 0;
        n_assert++; if (qb.count !== 12'd1 || qb.rd_data !== 16'h1111) begin n_fail++; $display("FAIL ign_load_phase got %0d/%h want 1/1111", qb.count, qb.rd_data); end
        n_assert++; if (qb.underflow !== 1'b0) begin n_fail++; $display("FAIL ign_underflow got %b want 0", qb.underflow); end
        qb.solving = 1; qb.load_valid = 1; qb.load_data = 16'h2222;
        step();
        qb.load_valid = 0;
        n_assert++; if (qb.count !== 12'd1 || qb.rd_data !== 16'h1111) begin n_fail++; $display("FAIL ign_solve_phase got %0d/%h want 1/1111", qb.count, qb.rd_data); end
        qb.clear = 1; step(); qb.clear = 0;
        $display("test_ignore done");
    endtask

    task automatic test_overflow_small();
        qs.solving = 0;
        for (int i = 1; i <= 4; i++) begin
            qs.load_valid = 1; qs.load_data = 16'(i);
            step();
        end
        n_assert++; if (qs.full !== 1'b1 || qs.count !== 3'd4) begin n_fail++; $display("FAIL ovf_full got %b/%0d want 1/4", qs.full, qs.count); end
        n_assert++; if (qs.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", qs.overflow); end
        qs.load_data = 16'hBEEF;
        step();
        qs.load_valid = 0;
        n_assert++; if (qs.overflow !== 1'b1 || qs.full !== 1'b1 || qs.count !== 3'd4) begin n_fail++; $display("FAIL ovf_drop got ovf=%b full=%b cnt=%0d want 1/1/4", qs.overflow, qs.full, qs.count); end
        n_assert++; if (qs.rd_data !== 16'h0001) begin n_fail++; $display("FAIL ovf_head got %h want 0001", qs.rd_data); end
        $display("test_overflow_small done");
    endtask

    task automatic test_full_push_pop_small();
        logic [15:0] exp [4] = '{16'h0002, 16'h0003, 16'h0004, 16'h00AA};
        qs.solving = 1; qs.push = 1; qs.push_data = 16'h00AA; qs.pop = 1;
        step();
        qs.push = 0; qs.pop = 0;
        n_assert++; if (qs.count !== 3'd4 || qs.full !== 1'b1) begin n_fail++; $display("FAIL fpp_count got %0d/%b want 4/1", qs.count, qs.full); end
        for (int i = 0; i < 4; i++) begin
            n_assert++; if (qs.rd_data !== exp[i]) begin n_fail++; $display("FAIL fpp_data[%0d] got %h want %h", i, qs.rd_data, exp[i]); end
            qs.pop = 1;
            step();
            qs.pop = 0;
            $display("small pop %0d count=%0d", i, qs.count);
        end
        n_assert++; if (qs.rd_valid !== 1'b0 || qs.count !== 3'd0) begin n_fail++; $display("FAIL fpp_empty got %b/%0d want 0/0", qs.rd_valid, qs.count); end
        n_assert++; if (qs.max_count !== 3'd4 || qs.underflow !== 1'b0) begin n_fail++; $display("FAIL fpp_max_uf got %0d/%b want 4/0", qs.max_count, qs.underflow); end
    endtask

    task automatic test_async_reset_and_clear();
        qb.solving = 0;
        for (int i = 0; i < 3; i++) begin
            qb.load_valid = 1; qb.load_data = 16'h0100 + 16'(i);
            step();
        end
        qb.load_valid = 0;
        n_assert++; if (qb.count !== 12'd3) begin n_fail++; $display("FAIL ar_pre got %0d want 3", qb.count); end
        #2 rst_n = 0;
        #1;
        n_assert++; if (qb.count !== 12'd0 || qb.max_count !== 12'd0 || qb.rd_valid !== 1'b0 || qb.rd_data !== 16'h0) begin n_fail++; $display("FAIL ar_during got cnt=%0d max=%0d v=%b d=%h want 0", qb.count, qb.max_count, qb.rd_valid, qb.rd_data); end
        rst_n = 1;
        step();
        n_assert++; if (qb.count !== 12'd0 || qb.max_count !== 12'd0 || qb.rd_valid !== 1'b0) begin n_fail++; $display("FAIL ar_after got cnt=%0d max=%0d v=%b want 0", qb.count, qb.max_count, qb.rd_valid); end
        for (int i = 0; i < 2; i++) begin
            qb.load_valid = 1; qb.load_data = 16'h0200 + 16'(i);
            step();
        end
        qb.load_valid = 0;
        n_assert++; if (qb.count !== 12'd2) begin n_fail++; $display("FAIL clr_pre got %0d want 2", qb.count); end
        qb.clear = 1; qb.load_valid = 1; qb.load_data = 16'h0300;
        step();
        qb.clear = 0; qb.load_valid = 0;
        n_assert++; if (qb.count !== 12'd0 || qb.max_count !== 12'd0 || qb.rd_valid !== 1'b0 || qb.rd_data !== 16'h0) begin n_fail++; $display("FAIL clr_after got cnt=%0d max=%0d v=%b d=%h want 0", qb.count, qb.max_count, qb.rd_valid, qb.rd_data); end
        $display("test_async_reset_and_clear done");
    endtask

    initial begin
        idle_all();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1;
        step();
        test_load_pop();
        test_empty_push_pop();
        test_ignore();
        test_overflow_small();
        test_full_push_pop_small();
        test_async_reset_and_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/option_queue.md
Name: option_queue

Overview:
- Circular FIFO of 16-bit line words that feeds the line solver.
- Load phase: the board parser writes every line header and every candidate option into the queue.
- Solve phase: the solver pops the head word on `new_line`, and re-enqueues words still valid via `put_back_to_FIFO`/`new_option`.
- The queue therefore recirculates the surviving option set until the solver reports solved.

Parameters:
- WIDTH, 16, bits per queued word (line index or option bitmask).
- DEPTH, 2048, number of entries. Need not be a power of two; must be ≥ 22·(84+1) for an 11x11 board.
- CNT_W, $clog2(DEPTH+1), width of occupancy counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush; empties the queue and clears flags
- solving  in  1  0 = load phase, 1 = solve phase
- load_valid  in  1  parser write strobe
- load_data  in  WIDTH  parser word
- pop  in  1  solver consumes head word (solver new_line)
- push  in  1  solver re-enqueue strobe (solver put_back_to_FIFO)
- push_data  in  WIDTH  solver word (solver new_option)
- rd_data  out  WIDTH  head word, show-ahead (to solver option)
- rd_valid  out  1  queue non-empty
- count  out  CNT_W  current occupancy
- max_count  out  CNT_W  high-water mark since reset/clear
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a pop hit an empty queue

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: while rst_n=0, all of the following are 0:
  - wr_ptr, rd_ptr, count, max_count, overflow, underflow
  - rd_valid, full
  - rd_data
  - Memory contents are not reset.
- clear: highest synchronous priority. On the next edge it gives the same values as reset (memory untouched). All strobes in that cycle are ignored.
- Write source selection:
  - solving=0: write strobe is load_valid, data is load_data. push and pop are ignored.
  - solving=1: write strobe is push, data is push_data. load_valid is ignored.
- Read path:
  - rd_data = mem[rd_ptr] combinationally when count>0, else 0.
  - Zero latency: the word after a pop is visible the cycle after the pop edge.
- Write: on a strobe with (count<DEPTH, or a simultaneous accepted pop), mem[wr_ptr] <= data and wr_ptr advances.
- Pop: on pop with count>0, rd_ptr advances. Pop with count==0 is ignored and sets underflow.
- Pointer wrap: ptr+1 == DEPTH → 0 (explicit compare, no modulo).
- Count update: +1 on write only, −1 on pop only, unchanged on both.
- Simultaneous events:
  - Empty queue with push+pop: pop is rejected (underflow set); push is accepted; count becomes 1.
  - Full queue with push+pop: both are accepted; count stays DEPTH; the written word lands in the slot just vacated.
  - Full queue with write only: word dropped, overflow set, pointers unchanged.
- Sticky flags clear only on reset or clear.
- max_count <= max(max_count, next count), registered.
- full and rd_valid are derived from the registered count. No extra latency.
- Changing solving mid-stream does not alter contents. Occupancy carries from load into solve phase.
- Reset mid-operation: takes effect immediately and asynchronously. Queue reads as empty on release.

Decomposition:
- Shared package nonogram_pkg:
  - OPT_W=16
  - MAX_ROWS=11, MAX_COLS=11, MAX_NUM_OPTIONS=84
  - QUEUE_DEPTH=2048
  - typedef logic [OPT_W-1:0] opt_word_t
- One natural sub-module: option_queue_ram.
  - Single write port, asynchronous read port, DEPTH x WIDTH, no reset.
  - Keeps storage inferable as distributed RAM.
- Pointer, count and flag logic stay in option_queue.

Test Plan:
- Load 5 words 0x0003,0x0005,0x0006,0x0001,0x0004 with solving=0, then pop ×5 with solving=1 → rd_data sequence matches input order; count 5→0; rd_valid drops after the 5th pop; underflow=0.
- DEPTH=4 instance: load 4 words, then a 5th load of 0xBEEF → full=1, overflow=1, count=4; the 0xBEEF word is never read out.
- DEPTH=4 instance, full: push 0x00AA with pop in the same cycle → count stays 4. After 3 further pops, rd_data=0x00AA (wrap exercised).
- Empty queue, solving=1, push 0x0012 with pop → underflow=1, count=1, rd_data=0x0012 the next cycle.
- solving=0: pop and push each asserted with data 0x7777 → ignored; count unchanged. Then load_valid with solving=1 → ignored.
- Load 3 words, deassert rst_n between edges → all outputs 0 immediately. After release: count=0, max_count=0, rd_valid=0. A subsequent clear on a 2-entry queue gives the same result.
